// File: rtl/cov_scan_pkg.sv
// Shared types and sizing helpers for the coverage scan controller.
// Optional feature macro used by the top: COV_SCAN_AUTO_REARM_EN.
package cov_scan_pkg;

    localparam int DEF_NUM_POINTS = 14;
    localparam int DEF_WINDOW_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ARMED,
        ST_SCAN,
        ST_REPORT
    } cov_scan_state_e;

    // Width of the point select; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold a count from 0 to n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cov_window_cnt.sv
// Loadable down-counter timing the coverage measurement window.
// A loaded value of zero means the window is unbounded; the counter then
// holds at zero and never expires.
module cov_window_cnt
    import cov_scan_pkg::*;
#(
    parameter int WINDOW_W = DEF_WINDOW_W
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_load,
    input  logic [WINDOW_W-1:0] i_load_val,
    input  logic                i_dec,
    output logic                o_expire,
    output logic                o_unbounded
);

    logic [WINDOW_W-1:0] r_count;

    // Load has priority over decrement; decrement stops at zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expire    = i_dec && (r_count == WINDOW_W'(1));
    assign o_unbounded = (r_count == '0);

endmodule

// File: rtl/cov_scan_ctrl.sv
// Run-time sequencer for coverage instrumentation: optionally clears the
// counters, opens a timed or stop-terminated enable window, scans every
// coverage point through the select/hit mux and reports the covered count.
// Optional feature macro: COV_SCAN_AUTO_REARM_EN (adds auto_rearm input).
module cov_scan_ctrl
    import cov_scan_pkg::*;
#(
    parameter int NUM_POINTS = DEF_NUM_POINTS,
    parameter int WINDOW_W   = DEF_WINDOW_W,
    parameter int SEL_W      = sel_width(NUM_POINTS),
    parameter int CNT_W      = cnt_width(NUM_POINTS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                clear_on_start,
    input  logic [WINDOW_W-1:0] window_cycles,
    output logic                cov_en,
    output logic                cov_clr,
    output logic [SEL_W-1:0]    pt_sel,
    input  logic                pt_hit,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [CNT_W-1:0]    res_covered,
    output logic [CNT_W-1:0]    res_total,
`ifdef COV_SCAN_AUTO_REARM_EN
    input  logic                auto_rearm,
`endif
    output logic                busy
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_POINTS - 1);
    localparam logic [CNT_W-1:0] TOTAL    = CNT_W'(NUM_POINTS);

    cov_scan_state_e     r_state;
    cov_scan_state_e     w_next;
    logic [SEL_W-1:0]    r_pt_sel;
    logic [CNT_W-1:0]    r_acc;
    logic                w_load;
    logic [WINDOW_W-1:0] w_load_val;
    logic                w_dec;
    logic                w_expire;
    logic                w_unbounded;

    cov_window_cnt #(
        .WINDOW_W (WINDOW_W)
    ) u_window (
        .i_clk       (clock),
        .i_rst       (reset),
        .i_load      (w_load),
        .i_load_val  (w_load_val),
        .i_dec       (w_dec),
        .o_expire    (w_expire),
        .o_unbounded (w_unbounded)
    );

`ifdef COV_SCAN_AUTO_REARM_EN
    logic [WINDOW_W-1:0] r_win_cap;
    logic                r_cancel;

    // Remember the last accepted window length and any stop seen in REPORT.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_win_cap <= '0;
            r_cancel  <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_win_cap <= window_cycles;
            end
            r_cancel <= (r_state == ST_REPORT) && (r_cancel || stop);
        end
    end
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and Moore outputs.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = window_cycles;
        w_dec      = 1'b0;
        cov_en     = 1'b0;
        cov_clr    = 1'b0;
        res_valid  = 1'b0;
        busy       = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = clear_on_start ? ST_CLEAR : ST_ARMED;
                end
            end
            ST_CLEAR: begin
                cov_clr = 1'b1;
                w_next  = ST_ARMED;
            end
            ST_ARMED: begin
                cov_en = 1'b1;
                w_dec  = !w_unbounded;
                if (stop || w_expire) begin
                    w_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (r_pt_sel == LAST_SEL) begin
                    w_next = ST_REPORT;
                end
            end
            ST_REPORT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_next = ST_IDLE;
`ifdef COV_SCAN_AUTO_REARM_EN
                    // A stop on the handshake cycle itself also cancels.
                    if (auto_rearm && !r_cancel && !stop) begin
                        w_next     = ST_ARMED;
                        w_load     = 1'b1;
                        w_load_val = r_win_cap;
                    end
`endif
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Point select walk and saturating covered-point accumulator.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pt_sel <= '0;
            r_acc    <= '0;
        end else if ((r_state == ST_ARMED) && (w_next == ST_SCAN)) begin
            r_pt_sel <= '0;
            r_acc    <= '0;
        end else if (r_state == ST_SCAN) begin
            if (pt_hit && (r_acc != TOTAL)) begin
                r_acc <= r_acc + 1'b1;
            end
            r_pt_sel <= (r_pt_sel == LAST_SEL) ? '0 : r_pt_sel + 1'b1;
        end
    end

    assign pt_sel      = r_pt_sel;
    assign res_covered = r_acc;
    assign res_total   = TOTAL;

endmodule
